// File: rtl/meas_report_pkg.sv
// Shared constants, FSM state type and checksum helper for the measurement report UART.
// Latency: none (declarations only).
// Backpressure: not applicable.
package meas_report_pkg;

    localparam logic [7:0] FRAME_HDR = 8'hA5;
    localparam int         FRAME_LEN = 10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT,
        DONE
    } state_e;

    // Sum modulo 256 of every payload byte; the header is not covered.
    function automatic logic [7:0] frame_csum(
        input logic        flag,
        input logic [15:0] freq,
        input logic [31:0] pwr,
        input logic [7:0]  mod
    );
        return {7'b0, flag} + freq[15:8] + freq[7:0]
             + pwr[31:24] + pwr[23:16] + pwr[15:8] + pwr[7:0] + mod;
    endfunction

endpackage

// File: rtl/meas_report_uart_tx_byte.sv
// 8N1 byte serialiser: start bit, 8 data bits LSB first, stop bit, each BAUD_DIV cycles.
// Latency: start bit appears on tx in the same cycle start is asserted (tx is decoded, not registered).
// Backpressure: caller must only pulse start while busy is low; done pulses in the last stop-bit cycle.
module uart_tx_byte #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int            BW        = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    logic          active_q, active_d;
    logic [3:0]    bit_q,    bit_d;
    logic [BW-1:0] baud_q,   baud_d;
    logic [7:0]    data_q,   data_d;

    // Bit/baud sequencing. The start cycle itself counts as the first cycle
    // of the start bit, so the baud counter is preloaded with 1.
    always_comb begin
        active_d = active_q;
        bit_d    = bit_q;
        baud_d   = baud_q;
        data_d   = data_q;
        done     = 1'b0;
        if (start) begin
            active_d = 1'b1;
            bit_d    = 4'd0;
            baud_d   = BW'(1);
            data_d   = data;
        end else if (active_q) begin
            if (baud_q == BAUD_LAST) begin
                baud_d = '0;
                if (bit_q == 4'd9) begin
                    active_d = 1'b0;
                    done     = 1'b1;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end else begin
                baud_d = baud_q + BW'(1);
            end
        end
    end

    // Line level: idle high, start bit low, data LSB first, stop bit high.
    always_comb begin
        tx = 1'b1;
        if (start) begin
            tx = 1'b0;
        end else if (active_q) begin
            if (bit_q == 4'd0) begin
                tx = 1'b0;
            end else if (bit_q == 4'd9) begin
                tx = 1'b1;
            end else begin
                tx = data_q[3'(bit_q - 4'd1)];
            end
        end
    end

    assign busy = start | active_q;

    // Serialiser state registers; reset returns the line to idle at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            bit_q    <= 4'd0;
            baud_q   <= '0;
            data_q   <= 8'd0;
        end else begin
            active_q <= active_d;
            bit_q    <= bit_d;
            baud_q   <= baud_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: rtl/meas_report_uart.sv
// Periodic / on-demand snapshot of measurement results sent as a 10-byte 8N1 UART frame.
// Latency: trigger in cycle n -> tx_busy at n+1, start bit at n+2; frame_done one cycle after last stop bit.
// Backpressure: one trigger while busy is held pending and starts the cycle after frame_done; more are dropped.
module meas_report_uart
    import meas_report_pkg::*;
#(
    parameter int REPORT_PERIOD = 5_000_000,
    parameter int BAUD_DIV      = 434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        report_req,
    input  logic        is_sine_wave,
    input  logic [15:0] freq_out,
    input  logic [31:0] papr,
    input  logic [7:0]  ma,
    output logic        uart_tx,
    output logic        tx_busy,
    output logic        frame_done
);

    localparam logic [31:0] PERIOD_LAST =
        (REPORT_PERIOD > 0) ? 32'(REPORT_PERIOD - 1) : 32'd0;

    state_e      state_q, state_d;
    logic [3:0]  idx_q,   idx_d;
    logic        pend_q,  pend_d;
    logic [31:0] period_q, period_d;
    logic        flag_q,  flag_d;
    logic [15:0] freq_q,  freq_d;
    logic [31:0] papr_q,  papr_d;
    logic [7:0]  ma_q,    ma_d;
    logic [7:0]  csum_q,  csum_d;

    logic        period_wrap;
    logic        trigger;
    logic        frame_active;
    logic        byte_start;
    logic        byte_busy;
    logic        byte_done;
    logic [7:0]  cur_byte;

    // Free-running report period counter; a zero period never wraps.
    always_comb begin
        period_d    = period_q;
        period_wrap = 1'b0;
        if (REPORT_PERIOD > 0) begin
            if (period_q == PERIOD_LAST) begin
                period_d    = 32'd0;
                period_wrap = 1'b1;
            end else begin
                period_d = period_q + 32'd1;
            end
        end
    end

    // A wrap and a request in the same cycle merge into one trigger.
    assign trigger      = period_wrap | report_req;
    assign frame_active = (state_q == LOAD) || (state_q == SEND) || (state_q == WAIT);
    assign tx_busy      = frame_active | byte_busy;
    assign frame_done   = (state_q == DONE);

    // Frame sequencing, pending-trigger capture and input snapshot.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pend_d     = pend_q;
        flag_d     = flag_q;
        freq_d     = freq_q;
        papr_d     = papr_q;
        ma_d       = ma_q;
        csum_d     = csum_q;
        byte_start = 1'b0;

        if (trigger && frame_active) begin
            pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (trigger || pend_q) begin
                    state_d = LOAD;
                    pend_d  = 1'b0;
                end
            end
            LOAD: begin
                flag_d  = is_sine_wave;
                freq_d  = freq_out;
                papr_d  = papr;
                ma_d    = ma;
                csum_d  = frame_csum(is_sine_wave, freq_out, papr, ma);
                idx_d   = 4'd0;
                state_d = SEND;
            end
            SEND: begin
                byte_start = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                if (byte_done) begin
                    if (idx_q == 4'(FRAME_LEN - 1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = SEND;
                    end
                end
            end
            DONE: begin
                // tx_busy is already low here, so a fresh trigger starts directly.
                if (pend_q || trigger) begin
                    state_d = LOAD;
                    pend_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Byte selection from the snapshot, in wire order.
    always_comb begin
        cur_byte = FRAME_HDR;
        case (idx_q)
            4'd0:    cur_byte = FRAME_HDR;
            4'd1:    cur_byte = {7'b0, flag_q};
            4'd2:    cur_byte = freq_q[15:8];
            4'd3:    cur_byte = freq_q[7:0];
            4'd4:    cur_byte = papr_q[31:24];
            4'd5:    cur_byte = papr_q[23:16];
            4'd6:    cur_byte = papr_q[15:8];
            4'd7:    cur_byte = papr_q[7:0];
            4'd8:    cur_byte = ma_q;
            4'd9:    cur_byte = csum_q;
            default: cur_byte = FRAME_HDR;
        endcase
    end

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx_byte (
        .clk   (clk),
        .rst_n (rst_n),
        .start (byte_start),
        .data  (cur_byte),
        .tx    (uart_tx),
        .busy  (byte_busy),
        .done  (byte_done)
    );

    // Control and snapshot registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= 4'd0;
            pend_q   <= 1'b0;
            period_q <= 32'd0;
            flag_q   <= 1'b0;
            freq_q   <= 16'd0;
            papr_q   <= 32'd0;
            ma_q     <= 8'd0;
            csum_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            period_q <= period_d;
            flag_q   <= flag_d;
            freq_q   <= freq_d;
            papr_q   <= papr_d;
            ma_q     <= ma_d;
            csum_q   <= csum_d;
        end
    end

endmodule
